// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT butterfly sequencer.
// Holds the FFT size, the address/counter widths, the sequencer state
// encoding and the stage-index type used by the sequencer and the
// address calculator.
package fft_pkg;

    localparam int unsigned LOG_N   = 4;
    localparam int unsigned N       = 1 << LOG_N;
    localparam int unsigned HALF_N  = N / 2;
    localparam int unsigned ADDR_W  = LOG_N;      // data-memory address width
    localparam int unsigned TW_W    = LOG_N - 1;  // twiddle ROM address width
    localparam int unsigned J_W     = LOG_N - 1;  // butterfly index within a stage
    localparam int unsigned STAGE_W = 2;          // holds 0..LOG_N-1
    localparam int unsigned GAP_W   = 4;          // inter-stage gap counter, 0..15

    typedef logic [STAGE_W-1:0] stage_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

endpackage

// File: rtl/fft_bf_addr_calc.sv
// Combinational butterfly address generator for a radix-2 DIT FFT with
// bit-reversed input.
//   s_i       : stage index
//   j_i       : butterfly index within the stage
//   addr_a_o  : upper input address  = grp*2h + pos
//   addr_b_o  : lower input address  = addr_a + h
//   tw_o      : twiddle ROM address  = pos << (LOG_N-1-s)
// with h = 2**s, pos = j & (h-1), grp = j >> s.
module fft_bf_addr_calc
    import fft_pkg::*;
(
    input  logic [STAGE_W-1:0] s_i,
    input  logic [J_W-1:0]     j_i,
    output logic [ADDR_W-1:0]  addr_a_o,
    output logic [ADDR_W-1:0]  addr_b_o,
    output logic [TW_W-1:0]    tw_o
);

    logic [ADDR_W-1:0]  j_c;
    logic [ADDR_W-1:0]  h_c;
    logic [ADDR_W-1:0]  pos_c;
    logic [ADDR_W-1:0]  grp_c;
    logic [ADDR_W-1:0]  a_c;
    logic [STAGE_W-1:0] tw_sh_c;

    // Split j into group and in-group position, then rebuild the addresses.
    always_comb begin
        j_c     = ADDR_W'(j_i);
        h_c     = ADDR_W'(1) << s_i;
        pos_c   = j_c & (h_c - ADDR_W'(1));
        grp_c   = j_c >> s_i;
        // Two shifts instead of s+1 so s=LOG_N-1 does not wrap the shift amount.
        a_c     = ((grp_c << s_i) << 1) + pos_c;
        tw_sh_c = STAGE_W'(LOG_N - 1) - s_i;
    end

    assign addr_a_o = a_c;
    assign addr_b_o = a_c + h_c;
    // pos < 2**s, so the shifted value always fits the twiddle address.
    assign tw_o     = TW_W'(pos_c << tw_sh_c);

endmodule

// File: rtl/fft_bf_sequencer.sv
// Butterfly sequencer: requester side of the FFT twiddle ROM.
// Walks every butterfly of an in-place N-point FFT, stage by stage, issuing
// the twiddle ROM read one cycle after the issue decision and presenting
// the matching data addresses one cycle later, aligned with the ROM output.
//   clk, rst      : clock, synchronous active-high reset
//   start         : frame start, only honoured in IDLE
//   stall         : holds off new butterfly issue while in RUN
//   tf_addr(_nd)  : twiddle ROM address and read strobe
//   bf_nd         : butterfly valid, aligned with the ROM's tf_out
//   bf_addr_a/b   : data addresses of the butterfly inputs
//   bf_stage      : stage of the presented butterfly
//   bf_last       : final butterfly of the frame (only with bf_nd)
//   busy, done    : frame in progress / one-cycle end-of-frame pulse
module fft_bf_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    output logic [TW_W-1:0]    tf_addr,
    output logic               tf_addr_nd,
    output logic               bf_nd,
    output logic [ADDR_W-1:0]  bf_addr_a,
    output logic [ADDR_W-1:0]  bf_addr_b,
    output logic [STAGE_W-1:0] bf_stage,
    output logic               bf_last,
    output logic               busy,
    output logic               done
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    seq_state_e         state_q;
    stage_t             s_q;
    logic [J_W-1:0]     j_q;
    logic [GAP_W-1:0]   gap_q;
    logic               drain_q;

    // First pipeline stage: twiddle request plus the data side waiting for tf_out.
    logic [TW_W-1:0]    tf_addr_q;
    logic               tf_nd_q;
    logic [ADDR_W-1:0]  p1_a_q;
    logic [ADDR_W-1:0]  p1_b_q;
    stage_t             p1_stage_q;
    logic               p1_last_q;

    // Second pipeline stage: butterfly presented to the datapath.
    logic               bf_nd_q;
    logic [ADDR_W-1:0]  bf_a_q;
    logic [ADDR_W-1:0]  bf_b_q;
    stage_t             bf_stage_q;
    logic               bf_last_q;

    logic               busy_q;
    logic               done_q;

    logic [ADDR_W-1:0]  calc_a_c;
    logic [ADDR_W-1:0]  calc_b_c;
    logic [TW_W-1:0]    calc_tw_c;
    logic               issue_c;
    logic               last_j_c;
    logic               last_s_c;

    fft_bf_addr_calc u_addr_calc (
        .s_i      (s_q),
        .j_i      (j_q),
        .addr_a_o (calc_a_c),
        .addr_b_o (calc_b_c),
        .tw_o     (calc_tw_c)
    );

    assign issue_c  = (state_q == ST_RUN) && !stall;
    assign last_j_c = (j_q == J_W'(HALF_N - 1));
    assign last_s_c = (s_q == stage_t'(LOG_N - 1));

    // Sequencer FSM, counters and the two-deep alignment pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            j_q        <= '0;
            gap_q      <= '0;
            drain_q    <= 1'b0;
            tf_addr_q  <= '0;
            tf_nd_q    <= 1'b0;
            p1_a_q     <= '0;
            p1_b_q     <= '0;
            p1_stage_q <= '0;
            p1_last_q  <= 1'b0;
            bf_nd_q    <= 1'b0;
            bf_a_q     <= '0;
            bf_b_q     <= '0;
            bf_stage_q <= '0;
            bf_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Pipeline advances every cycle; stall only blocks new issue.
            tf_nd_q <= issue_c;
            if (issue_c) begin
                tf_addr_q  <= calc_tw_c;
                p1_a_q     <= calc_a_c;
                p1_b_q     <= calc_b_c;
                p1_stage_q <= s_q;
                p1_last_q  <= last_s_c && last_j_c;
            end

            bf_nd_q   <= tf_nd_q;
            bf_last_q <= tf_nd_q && p1_last_q;
            if (tf_nd_q) begin
                bf_a_q     <= p1_a_q;
                bf_b_q     <= p1_b_q;
                bf_stage_q <= p1_stage_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        s_q     <= '0;
                        j_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (!last_j_c) begin
                            j_q <= j_q + J_W'(1);
                        end else if (last_s_c) begin
                            state_q <= ST_DRAIN;
                            drain_q <= 1'b0;
                        end else if (GAP_CYCLES == 0) begin
                            s_q <= s_q + stage_t'(1);
                            j_q <= '0;
                        end else begin
                            state_q <= ST_GAP;
                            gap_q   <= GAP_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q <= GAP_W'(1)) begin
                        state_q <= ST_RUN;
                        s_q     <= s_q + stage_t'(1);
                        j_q     <= '0;
                        gap_q   <= '0;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Two cycles: last tf_addr_nd, then last bf_nd.
                    if (drain_q) begin
                        state_q <= ST_IDLE;
                        drain_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tf_addr    = tf_addr_q;
    assign tf_addr_nd = tf_nd_q;
    assign bf_nd      = bf_nd_q;
    assign bf_addr_a  = bf_a_q;
    assign bf_addr_b  = bf_b_q;
    assign bf_stage   = bf_stage_q;
    assign bf_last    = bf_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/fft_bf_sequencer.md
Name: fft_bf_sequencer

Overview:
Requester side of the FFT twiddle-factor ROM. For each frame it steps through every radix-2 decimation-in-time butterfly of an in-place N-point FFT with bit-reversed input. For each butterfly it issues the twiddle ROM read (tf_addr, tf_addr_nd). One cycle later it presents the matching data-memory addresses and strobe, aligned with the ROM's registered tf_out. It sits between the frame controller (start/done) and the butterfly datapath (bf_* outputs).

Parameters:
LOG_N, 4, log2 of FFT size; N = 2**LOG_N = 16; twiddle address width LOG_N-1 = 3.
GAP_CYCLES, 4, idle cycles inserted between stages to cover butterfly write-back latency; range 0..15.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  frame start request; sampled only in IDLE.
stall  in  1  issue throttle from datapath; gates new butterfly issue only.
tf_addr  out  LOG_N-1  twiddle ROM address.
tf_addr_nd  out  1  twiddle ROM read strobe.
bf_nd  out  1  butterfly valid; aligned with ROM tf_out.
bf_addr_a  out  LOG_N  data address of upper butterfly input.
bf_addr_b  out  LOG_N  data address of lower butterfly input.
bf_stage  out  2  stage index of the presented butterfly.
bf_last  out  1  marks the final butterfly of the frame, qualified by bf_nd.
busy  out  1  frame in progress.
done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset: state IDLE; stage counter s=0, butterfly counter j=0, gap counter 0. All outputs 0. In-flight strobes are discarded. Reset mid-frame aborts the frame with no done pulse.
- States: IDLE, RUN, GAP, DRAIN. All outputs are registered.
- IDLE: start=1 → RUN with s=0, j=0; busy=1 from the next cycle. start is ignored in all other states.
- RUN, issue cycle (stall=0): butterfly (s,j) is issued.
  - Next cycle: tf_addr_nd=1 and tf_addr=tw(s,j).
  - Cycle after that: bf_nd=1 with bf_addr_a, bf_addr_b, bf_stage=s, and bf_last=(s==LOG_N-1 && j==N/2-1).
- RUN with stall=1: no issue, counters hold, and tf_addr_nd=0 on the next cycle. Already-issued items still complete, so stall never freezes the pipeline.
- Address math, with h = 2**s, pos = j & (h-1), grp = j >> s:
  - bf_addr_a = grp*2h + pos
  - bf_addr_b = bf_addr_a + h
  - tw = pos << (LOG_N-1-s)
  - Results are unsigned and never exceed N-1.
- After issuing j=N/2-1:
  - If s<LOG_N-1: go to GAP, load the gap counter with GAP_CYCLES. When the count expires, s++, j=0, return to RUN. If GAP_CYCLES=0, go straight to RUN with the next stage.
  - If s=LOG_N-1: go to DRAIN.
- GAP counts every cycle regardless of stall.
- DRAIN lasts 2 cycles, until the last bf_nd has been presented. Then done=1 for 1 cycle, busy=0 in that same cycle, and the state returns to IDLE. A start sampled in the done cycle is accepted.
- Stall-free frame length: done is asserted (N/2)*LOG_N + (LOG_N-1)*GAP_CYCLES + 3 cycles after the start edge. For defaults this is 47 cycles.
- Every stall cycle in RUN delays done by exactly 1 cycle.
- tf_addr holds its last value when tf_addr_nd=0. bf_addr_* hold their values when bf_nd=0.

Decomposition:
- Shared package fft_pkg: LOG_N and N constants, address-width localparams, the sequencer state encoding (IDLE/RUN/GAP/DRAIN), and a stage-index type.
- One natural sub-module, fft_bf_addr_calc: purely combinational (s,j) → (addr_a, addr_b, tw). It is instantiated once and unit-tested exhaustively.
- Counters, FSM and the two-deep alignment pipeline stay in the top.

Test Plan:
1. Reset, then hold start=0 for 10 cycles → all outputs remain 0 and busy=0. Assert rst mid-frame (stage 1) → next cycle all outputs 0; a new start restarts from s=0, j=0.
2. Single frame, defaults, no stall:
   - exactly 32 tf_addr_nd pulses and 32 bf_nd pulses;
   - stage 0 j=6 → a=12, b=13, tw=0;
   - stage 1 j=3 → a=5, b=7, tw=4;
   - stage 2 j=5 → a=9, b=13, tw=2;
   - stage 3 j=5 → a=5, b=13, tw=5;
   - bf_last only on (3,7), where a=7, b=15, tw=7;
   - done exactly 47 cycles after start.
3. Each bf_nd check: bf_addr_* and bf_stage match the tf_addr issued one cycle earlier, and the ROM model's tf_out is consistent (e.g. tw=2 → {724,-724}).
4. Assert stall for 3 cycles at stage 2, j=4 → no tf_addr_nd in those cycles, sequence resumes at j=4 with nothing skipped or duplicated, done at cycle 50. Stall held through a GAP → done still at 47.
5. GAP_CYCLES=0 → done at 35 cycles, and no idle issue cycles between stages.
6. start pulsed while busy → ignored, and the frame completes normally. start held high → back-to-back frames, with RUN re-entered the cycle after done.
